// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, two bits per clock LSB-first, registered carry between slices.
// start is honoured only in IDLE; done is a one-cycle strobe with sum/cout valid.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  if (WIDTH < 2 || WIDTH % 2 != 0) begin : g_bad_width
    $error("serial_adder: WIDTH must be even and >= 2");
  end
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic             carry_q, cout_q, busy_q, done_q;
  logic [1:0]       lo, hi;
  logic             last;
  always_comb begin
    lo    = {1'b0, a_q[0]} + {1'b0, b_q[0]} + {1'b0, carry_q};
    hi    = {1'b0, a_q[1]} + {1'b0, b_q[1]} + {1'b0, lo[1]};
    // new slice enters at the top; after N shifts slice 0 lands in sum[1:0]
    sum_d = (WIDTH'({hi[0], lo[0]}) << (WIDTH - 2)) | (sum_q >> 2);
    last  = cnt_q == CW'(N - 1);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
          a_q     <= a;
          b_q     <= b;
          carry_q <= cin;
          cnt_q   <= '0;
        end
        RUN: begin
          a_q     <= a_q >> 2;
          b_q     <= b_q >> 2;
          carry_q <= hi[1];
          sum_q   <= sum_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cout_q  <= hi[1];
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for WIDTH=8 and WIDTH=2 instances sharing clock and reset.
module tb_serial_adder;
  logic clk = 1'b0;
  logic reset_n;
  logic start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;
  int total = 0;
  int bad = 0;
  int left8 = 0;
  int left2 = 0;
  logic [8:0] q8[$];
  logic [2:0] q2[$];
  logic [8:0] e8;
  logic [2:0] e2;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder #(.WIDTH(2)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference protocol: left = cycles until back in IDLE (N RUN cycles + 1 DONE)
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left8 <= 0;
      q8.delete();
    end else if (left8 == 0) begin
      if (start8) begin
        q8.push_back(9'(a8) + 9'(b8) + 9'(cin8));
        left8 <= 5;
      end
    end else left8 <= left8 - 1;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left2 <= 0;
      q2.delete();
    end else if (left2 == 0) begin
      if (start2) begin
        q2.push_back(3'(a2) + 3'(b2) + 3'(cin2));
        left2 <= 2;
      end
    end else left2 <= left2 - 1;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("busy8", 16'(busy8), 16'(left8 > 1));
      chk("done8", 16'(done8), 16'(left8 == 1));
      if (left8 == 1) begin
        chk("sb8_size", 16'(q8.size()), 16'd1);
        if (q8.size() != 0) begin
          e8 = q8.pop_front();
          chk("sum8", 16'(sum8), 16'(e8[7:0]));
          chk("cout8", 16'(cout8), 16'(e8[8]));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("busy2", 16'(busy2), 16'(left2 > 1));
      chk("done2", 16'(done2), 16'(left2 == 1));
      if (left2 == 1) begin
        chk("sb2_size", 16'(q2.size()), 16'd1);
        if (q2.size() != 0) begin
          e2 = q2.pop_front();
          chk("sum2", 16'(sum2), 16'(e2[1:0]));
          chk("cout2", 16'(cout2), 16'(e2[2]));
        end
      end
    end
  end

  task automatic wait_idle8();
    int n = 0;
    while (left8 != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // call at a negedge; operands are scrambled right after the accepting edge
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic c,
                      input logic [8:0] exp, input string tag);
    int n = 0;
    wait_idle8();
    a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    while (!done8 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_res"}, 16'({cout8, sum8}), 16'(exp));
  endtask

  task automatic run2(input logic [1:0] x, input logic [1:0] y, input logic c);
    int n = 0;
    while (left2 != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    a2 = x; b2 = y; cin2 = c; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
    n = 0;
    while (!done2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rnd2_res", 16'({cout2, sum2}), 16'(3'(x) + 3'(y) + 3'(c)));
  endtask

  initial begin
    int dn;
    reset_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    #12;
    chk("rst_busy8", 16'(busy8), 16'd0);
    chk("rst_done8", 16'(done8), 16'd0);
    chk("rst_sum8", 16'(sum8), 16'd0);
    chk("rst_cout8", 16'(cout8), 16'd0);
    chk("rst_busy2", 16'(busy2), 16'd0);
    chk("rst_sum2", 16'(sum2), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run8(8'h3C, 8'h41, 1'b0, 9'h07D, "t1");
    run8(8'hFF, 8'h01, 1'b0, 9'h100, "ripple");
    run8(8'hA5, 8'h5A, 1'b1, 9'h100, "cin");
    @(negedge clk);
    wait_idle8();
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    dn = 0;
    repeat (30) begin
      @(negedge clk);
      if (done8) begin
        dn++;
        chk("held_res", 16'({cout8, sum8}), 16'h003);
      end
    end
    start8 = 1'b0;
    chk("held_dones", 16'(dn), 16'd5);
    @(negedge clk);
    wait_idle8();
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", 16'(busy8), 16'd0);
    chk("arst_done", 16'(done8), 16'd0);
    chk("arst_sum", 16'(sum8), 16'd0);
    chk("arst_cout", 16'(cout8), 16'd0);
    repeat (3) @(negedge clk);
    chk("arst_hold", 16'({busy8, done8, cout8, sum8}), 16'd0);
    #2 reset_n = 1'b1;
    repeat (6) @(negedge clk);
    run8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "post_rst");
    fork
      for (int i = 0; i < 1000; i++) begin
        logic [7:0] x, y;
        logic c;
        x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
        run8(x, y, c, 9'(x) + 9'(y) + 9'(c), "rnd8");
      end
      for (int j = 0; j < 1000; j++) run2(2'($urandom), 2'($urandom), 1'($urandom));
    join
    repeat (4) @(negedge clk);
    chk("sb8_drained", 16'(q8.size()), 16'd0);
    chk("sb2_drained", 16'(q2.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
